// File: rtl/cpu_pkg.sv
// Shared widths, IR field positions, opcode and timing indices for the basic-computer control path.
// Pure declarations: no latency, no flow control.
package cpu_pkg;

    localparam int SC_W = 3;
    localparam int IR_W = 16;
    localparam int TV_W = 1 << SC_W;

    localparam int I_BIT = 15;
    localparam int OP_HI = 14;
    localparam int OP_LO = 12;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_ADD   = 3'd1,
        OP_LDA   = 3'd2,
        OP_STA   = 3'd3,
        OP_BUN   = 3'd4,
        OP_BSA   = 3'd5,
        OP_ISZ   = 3'd6,
        OP_REGIO = 3'd7
    } opcode_e;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;
    localparam int T7 = 7;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // An interrupt is pending when enabled and either I/O flag is up.
    function automatic logic int_request(input logic ien, input logic fgi, input logic fgo);
        return ien & (fgi | fgo);
    endfunction

endpackage

// File: rtl/seq_timing_unit_if.sv
// Control/status bundle between the sequencing stage and its environment.
// Plain wires: no latency, no backpressure.
interface seq_timing_unit_if;
    import cpu_pkg::*;

    logic            start;
    logic            stop;
    logic [IR_W-1:0] ir_in;
    logic            ir_ld;
    logic            sc_clr;
    logic            ien;
    logic            fgi;
    logic            fgo;
    logic [TV_W-1:0] dec_out1;
    logic [TV_W-1:0] dec_out2;
    logic            iff_data;
    logic            r;
    logic            s;
    logic [SC_W-1:0] sc;

    modport master (
        output start, stop, ir_in, ir_ld, sc_clr, ien, fgi, fgo,
        input  dec_out1, dec_out2, iff_data, r, s, sc
    );

    modport slave (
        input  start, stop, ir_in, ir_ld, sc_clr, ien, fgi, fgo,
        output dec_out1, dec_out2, iff_data, r, s, sc
    );

endinterface

// File: rtl/seq_timing_unit_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
// Combinational, no backpressure.
module dec3to8
    import cpu_pkg::*;
(
    input  logic [SC_W-1:0] sel_i,
    input  logic            en_i,
    output logic [TV_W-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_timing_unit.sv
// Start flop S, sequence counter SC, instruction register IR and interrupt flag R with T/D decode.
// Outputs follow registered state (IR loads visible next cycle); no backpressure, inputs act every cycle.
module seq_timing_unit
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    seq_timing_unit_if.slave   bus
);

    run_state_e      s_q, s_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            r_q, r_d;

    logic            running;
    logic [TV_W-1:0] t_vec;
    logic [TV_W-1:0] d_vec;
    opcode_e         op;
    logic            r_set;
    logic            r_clr;

    assign running = (s_q == ST_RUN);
    assign op      = opcode_e'(ir_q[OP_HI:OP_LO]);

    // Timing decode is gated by S so nothing fires while halted.
    dec3to8 u_tdec (
        .sel_i (sc_q),
        .en_i  (running),
        .dec_o (t_vec)
    );

    dec3to8 u_ddec (
        .sel_i (op),
        .en_i  (1'b1),
        .dec_o (d_vec)
    );

    // t_vec is already S-gated, so R can neither set nor clear while halted.
    assign r_set = running && !t_vec[T0] && !t_vec[T1] && !t_vec[T2]
                   && int_request(bus.ien, bus.fgi, bus.fgo);
    assign r_clr = r_q && t_vec[T2];

    always_comb begin
        s_d = s_q;
        if (bus.stop) begin
            s_d = ST_HALT;
        end else if (bus.start) begin
            s_d = ST_RUN;
        end

        sc_d = sc_q;
        if (bus.sc_clr) begin
            sc_d = '0;
        end else if (running) begin
            sc_d = sc_q + 1'b1;
        end

        ir_d = bus.ir_ld ? bus.ir_in : ir_q;

        r_d = r_q;
        if (r_clr) begin
            r_d = 1'b0;
        end else if (r_set) begin
            r_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= ST_HALT;
            sc_q <= '0;
            ir_q <= '0;
            r_q  <= 1'b0;
        end else begin
            s_q  <= s_d;
            sc_q <= sc_d;
            ir_q <= ir_d;
            r_q  <= r_d;
        end
    end

    assign bus.dec_out1 = t_vec;
    assign bus.dec_out2 = d_vec;
    assign bus.iff_data = ir_q[I_BIT];
    assign bus.r        = r_q;
    assign bus.s        = running;
    assign bus.sc       = sc_q;

endmodule

// File: tb/tb_seq_timing_unit.sv
// Directed bench for seq_timing_unit: vector table plus hand-written reset sequences.
module tb_seq_timing_unit;

    logic clk;
    logic rst_n;

    seq_timing_unit_if bus ();

    seq_timing_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic        ir_ld;
        logic [15:0] ir_in;
        logic        sc_clr;
        logic        ien;
        logic        fgi;
        logic        fgo;
        logic [7:0]  e_t;
        logic [7:0]  e_d;
        logic        e_i;
        logic        e_r;
        logic        e_s;
        logic [2:0]  e_sc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic st, input logic sp, input logic ld, input logic [15:0] ir,
                                input logic clr, input logic ien, input logic fgi, input logic fgo,
                                input logic [7:0] et, input logic [7:0] ed, input logic ei,
                                input logic er, input logic es, input logic [2:0] esc);
        vec_t v;
        v.start = st; v.stop = sp; v.ir_ld = ld; v.ir_in = ir; v.sc_clr = clr;
        v.ien = ien; v.fgi = fgi; v.fgo = fgo;
        v.e_t = et; v.e_d = ed; v.e_i = ei; v.e_r = er; v.e_s = es; v.e_sc = esc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] et, input logic [7:0] ed,
                             input logic ei, input logic er, input logic es, input logic [2:0] esc);
        check({tag, " dec_out1"}, 32'(bus.dec_out1), 32'(et));
        check({tag, " dec_out2"}, 32'(bus.dec_out2), 32'(ed));
        check({tag, " iff_data"}, 32'(bus.iff_data), 32'(ei));
        check({tag, " r"},        32'(bus.r),        32'(er));
        check({tag, " s"},        32'(bus.s),        32'(es));
        check({tag, " sc"},       32'(bus.sc),       32'(esc));
    endtask

    task automatic drive(input vec_t v);
        bus.start  = v.start;
        bus.stop   = v.stop;
        bus.ir_ld  = v.ir_ld;
        bus.ir_in  = v.ir_in;
        bus.sc_clr = v.sc_clr;
        bus.ien    = v.ien;
        bus.fgi    = v.fgi;
        bus.fgo    = v.fgo;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(mk(0,0,0,16'h0000,0,0,0,0, 8'h00,8'h00,0,0,0,3'd0));
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 8'h01, 0, 0, 0, 3'd0);

        //       st sp ld ir_in    clr ien fgi fgo  dec1   dec2   I  R  S  SC
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h00,8'h01,0,0,0,3'd0)); // idle until start
        vecs.push_back(mk(1,0,0,16'h0000,0,0,0,0, 8'h01,8'h01,0,0,1,3'd0));
        for (int k = 1; k < 8; k++)
            vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'(1 << k),8'h01,0,0,1,3'(k)));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h01,8'h01,0,0,1,3'd0)); // wrap 7->0
        vecs.push_back(mk(0,0,1,16'hB123,0,0,0,0, 8'h02,8'h08,1,0,1,3'd1));
        vecs.push_back(mk(0,0,0,16'h7000,0,0,0,0, 8'h04,8'h08,1,0,1,3'd2)); // no ir_ld: IR holds
        vecs.push_back(mk(0,0,0,16'h7000,0,0,0,0, 8'h08,8'h08,1,0,1,3'd3));
        vecs.push_back(mk(0,0,0,16'h0000,1,0,0,0, 8'h01,8'h08,1,0,1,3'd0)); // sc_clr at T3
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h02,8'h08,1,0,1,3'd1));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h04,8'h08,1,0,1,3'd2));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h08,8'h08,1,0,1,3'd3));
        vecs.push_back(mk(0,1,0,16'h0000,1,0,0,0, 8'h00,8'h08,1,0,0,3'd0)); // stop + sc_clr at T3
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h00,8'h08,1,0,0,3'd0));
        vecs.push_back(mk(1,0,0,16'h0000,0,0,0,0, 8'h01,8'h08,1,0,1,3'd0));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h02,8'h08,1,0,1,3'd1));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h04,8'h08,1,0,1,3'd2));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h08,8'h08,1,0,1,3'd3));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h10,8'h08,1,0,1,3'd4));
        vecs.push_back(mk(0,0,0,16'h0000,0,1,1,0, 8'h20,8'h08,1,1,1,3'd5)); // request at T4 sets R
        vecs.push_back(mk(0,0,0,16'h0000,1,0,0,0, 8'h01,8'h08,1,1,1,3'd0));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h02,8'h08,1,1,1,3'd1));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h04,8'h08,1,1,1,3'd2));
        vecs.push_back(mk(0,0,0,16'h0000,1,0,0,0, 8'h01,8'h08,1,0,1,3'd0)); // RT2 clears R
        vecs.push_back(mk(0,0,0,16'h0000,0,1,1,0, 8'h02,8'h08,1,0,1,3'd1)); // request at T0 ignored
        vecs.push_back(mk(0,0,0,16'h0000,0,1,1,0, 8'h04,8'h08,1,0,1,3'd2));
        vecs.push_back(mk(0,0,0,16'h0000,0,1,1,0, 8'h08,8'h08,1,0,1,3'd3));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,1, 8'h10,8'h08,1,0,1,3'd4)); // ien=0 blocks fgo
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,1, 8'h20,8'h08,1,0,1,3'd5));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,1, 8'h40,8'h08,1,0,1,3'd6));
        vecs.push_back(mk(0,0,1,16'h2ABC,1,0,0,0, 8'h01,8'h04,0,0,1,3'd0)); // ir_ld with sc_clr
        vecs.push_back(mk(1,1,0,16'h0000,0,0,0,0, 8'h00,8'h04,0,0,0,3'd1)); // stop beats start
        vecs.push_back(mk(1,0,0,16'h0000,0,0,0,0, 8'h02,8'h04,0,0,1,3'd1));
        vecs.push_back(mk(0,0,0,16'h0000,0,1,0,1, 8'h04,8'h04,0,0,1,3'd2));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h08,8'h04,0,0,1,3'd3));
        vecs.push_back(mk(0,0,0,16'h0000,0,1,1,0, 8'h10,8'h04,0,1,1,3'd4));
        vecs.push_back(mk(0,1,0,16'h0000,0,0,0,0, 8'h00,8'h04,0,1,0,3'd5)); // R holds across halt
        vecs.push_back(mk(0,0,0,16'h0000,0,1,1,0, 8'h00,8'h04,0,1,0,3'd5));
        vecs.push_back(mk(1,0,0,16'h0000,0,0,0,0, 8'h20,8'h04,0,1,1,3'd5));
        vecs.push_back(mk(0,0,0,16'h0000,0,0,0,0, 8'h40,8'h04,0,1,1,3'd6));

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_t, vecs[i].e_d, vecs[i].e_i,
                      vecs[i].e_r, vecs[i].e_s, vecs[i].e_sc);
        end

        // Asynchronous reset mid-instruction (SC=6, R=1, IR loaded), sampled before any edge.
        #3;
        rst_n = 1'b0;
        #1;
        check_all("midrst", 8'h00, 8'h01, 0, 0, 0, 3'd0);

        // After release, activity on other inputs must not start the block.
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(0,0,0,16'hFFFF,0,1,1,1, 8'h00,8'h00,0,0,0,3'd0));
        @(posedge clk);
        #1;
        check_all("post_idle", 8'h00, 8'h01, 0, 0, 0, 3'd0);
        drive(mk(1,0,0,16'h0000,0,0,0,0, 8'h00,8'h00,0,0,0,3'd0));
        @(posedge clk);
        #1;
        check_all("post_start", 8'h01, 8'h01, 0, 0, 1, 3'd0);
        drive(mk(0,0,0,16'h0000,0,0,0,0, 8'h00,8'h00,0,0,0,3'd0));
        @(posedge clk);
        #1;
        check_all("post_t1", 8'h02, 8'h01, 0, 0, 1, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
